// File: rtl/mips_run_controller_pkg.sv
// rtl/mips_run_controller_pkg.sv - shared state encoding and constants for the MIPS run controller
package mips_run_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_RUN,
    ST_DREQ,
    ST_DWAIT,
    ST_DOUT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam int CRST_CYCLES = 2;

  // States in which a new run may be launched.
  function automatic logic accepts_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/mips_run_controller_ena_pattern_gen.sv
// rtl/mips_run_controller_ena_pattern_gen.sv - periodic enable pattern: run cycles high, gap cycles low
module ena_pattern_gen #(
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [STALL_W-1:0] run,
  input  logic [STALL_W-1:0] gap,
  output logic               ena
);

  logic [STALL_W-1:0] cnt;
  logic               low;

  // A zero run or zero gap means no stalling, so the phase never leaves high.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      low <= 1'b0;
    end else if (run != '0 && gap != '0) begin
      if (!low) begin
        if (cnt == run - STALL_W'(1)) begin
          cnt <= '0;
          low <= 1'b1;
        end else begin
          cnt <= cnt + STALL_W'(1);
        end
      end else begin
        if (cnt == gap - STALL_W'(1)) begin
          cnt <= '0;
          low <= 1'b0;
        end else begin
          cnt <= cnt + STALL_W'(1);
        end
      end
    end
  end

  assign ena = ~low;

endmodule

// File: rtl/mips_run_controller.sv
// rtl/mips_run_controller.sv - core reset/run sequencer with stall pattern, failure detect and memory dump
module mips_run_controller
  import mips_run_controller_pkg::*;
#(
  parameter int N       = 32,
  parameter int ADDR_W  = 10,
  parameter int CYC_W   = 32,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CYC_W-1:0]   num_cycles,
  input  logic [STALL_W-1:0] stall_run,
  input  logic [STALL_W-1:0] stall_gap,
  input  logic [ADDR_W-1:0]  dump_start,
  input  logic [ADDR_W:0]    dump_stop,
  input  logic               cpu_failure,
  input  logic [N-1:0]       mem_rd_data,
  input  logic               dump_ready,
  output logic               cpu_rst,
  output logic               cpu_ena,
  output logic               mem_dbg_sel,
  output logic [ADDR_W-1:0]  mem_dbg_addr,
  output logic               dump_valid,
  output logic [N-1:0]       dump_data,
  output logic [ADDR_W-1:0]  dump_index,
  output logic [CYC_W-1:0]   cycles_run,
  output logic               busy,
  output logic               done,
  output logic               failed
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  state_t               state, state_next;
  logic [CYC_W-1:0]     num_cycles_q;
  logic [STALL_W-1:0]   stall_run_q, stall_gap_q;
  logic [ADDR_W:0]      addr, stop_q;
  logic [1:0]           crst_cnt;
  logic                 pat_ena;
  logic                 start_ok;
  logic [CYC_W-1:0]     cycles_inc;
  logic [ADDR_W:0]      addr_inc;

  assign start_ok     = start && accepts_start(state);
  assign cycles_inc   = cycles_run + CYC_W'(1);
  assign addr_inc     = addr + (ADDR_W+1)'(1);
  assign mem_dbg_addr = addr[ADDR_W-1:0];

  ena_pattern_gen #(.STALL_W(STALL_W)) u_pattern (
    .clk   (clk),
    .rst   (rst),
    .clear (state != ST_RUN),
    .run   (stall_run_q),
    .gap   (stall_gap_q),
    .ena   (pat_ena)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cpu_rst     = 1'b0;
    cpu_ena     = 1'b0;
    mem_dbg_sel = 1'b0;
    dump_valid  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    failed      = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_rst = 1'b1;
        busy    = 1'b0;
        if (start) state_next = ST_CRST;
      end
      ST_CRST: begin
        cpu_rst = 1'b1;
        if (crst_cnt == 2'(CRST_CYCLES - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        // The budget gate keeps num_cycles=0 from executing anything in its single RUN cycle.
        cpu_ena = pat_ena && (cycles_run < num_cycles_q);
        if (cpu_failure)                      state_next = ST_FAIL;
        else if (cycles_inc >= num_cycles_q)  state_next = (stop_q > addr) ? ST_DREQ : ST_DONE;
      end
      ST_DREQ: begin
        mem_dbg_sel = 1'b1;
        state_next  = ST_DWAIT;
      end
      ST_DWAIT: begin
        mem_dbg_sel = 1'b1;
        state_next  = ST_DOUT;
      end
      ST_DOUT: begin
        mem_dbg_sel = 1'b1;
        dump_valid  = 1'b1;
        if (dump_ready) state_next = (addr_inc == stop_q) ? ST_DONE : ST_DREQ;
      end
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b0;
        if (start) state_next = ST_CRST;
      end
      ST_FAIL: begin
        failed = 1'b1;
        busy   = 1'b0;
        if (start) state_next = ST_CRST;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_cycles_q <= '0;
      stall_run_q  <= '0;
      stall_gap_q  <= '0;
      addr         <= '0;
      stop_q       <= '0;
      crst_cnt     <= '0;
      cycles_run   <= '0;
      dump_data    <= '0;
      dump_index   <= '0;
    end else begin
      if (start_ok) begin
        num_cycles_q <= num_cycles;
        stall_run_q  <= stall_run;
        stall_gap_q  <= stall_gap;
        addr         <= {1'b0, dump_start};
        stop_q       <= (dump_stop > DEPTH) ? DEPTH : dump_stop;
        crst_cnt     <= '0;
        cycles_run   <= '0;
      end
      case (state)
        ST_CRST:  crst_cnt   <= crst_cnt + 2'd1;
        ST_RUN:   cycles_run <= cycles_inc;
        ST_DWAIT: begin
          dump_data  <= mem_rd_data;
          dump_index <= addr[ADDR_W-1:0];
        end
        ST_DOUT:  if (dump_ready) addr <= addr_inc;
        default: ;
      endcase
    end
  end

endmodule
